// File: rtl/buffer_output_multicast.sv
// Output buffer: queues PU result words and CU move instructions, then
// sends each word to one or more DTN destinations (multicast via cu_last=0).
module buffer_output_multicast #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 5,
    parameter int FROM_ADDR  = 0
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  pu_valid,
    output logic                  pu_ready,
    input  logic [DATA_WIDTH-1:0] pu_data,
    input  logic                  cu_valid,
    output logic                  cu_ready,
    input  logic [ADDR_WIDTH-1:0] cu_dest,
    input  logic                  cu_last,
    output logic                  dtn_valid,
    input  logic                  dtn_ready,
    output logic [ADDR_WIDTH-1:0] dtn_addr,
    output logic [ADDR_WIDTH-1:0] dtn_from,
    output logic [DATA_WIDTH-1:0] dtn_data,
    output logic                  idle
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam ptr_t LAST_PTR = ptr_t'(DEPTH - 1);
    localparam cnt_t FULL     = cnt_t'(DEPTH);

    function automatic ptr_t bump(input ptr_t p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    logic [DATA_WIDTH-1:0] dmem [DEPTH];
    logic [ADDR_WIDTH-1:0] idest [DEPTH];
    logic                  ilast [DEPTH];

    ptr_t dwr_q, dwr_d, drd_q, drd_d;
    ptr_t iwr_q, iwr_d, ird_q, ird_d;
    cnt_t dcnt_q, dcnt_d, icnt_q, icnt_d;

    logic                  vld_q, vld_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic d_push, d_pop, i_push, i_pop, issue;

    always_comb begin
        pu_ready = rst_n & (dcnt_q < FULL);
        cu_ready = rst_n & (icnt_q < FULL);
        d_push   = pu_valid & pu_ready;
        i_push   = cu_valid & cu_ready;
        issue    = (dcnt_q != '0) & (icnt_q != '0) & (~vld_q | dtn_ready);
        i_pop    = issue;
        // Data head survives until the copy flagged as last goes out
        d_pop    = issue & ilast[ird_q];

        dwr_d  = d_push ? bump(dwr_q) : dwr_q;
        drd_d  = d_pop  ? bump(drd_q) : drd_q;
        iwr_d  = i_push ? bump(iwr_q) : iwr_q;
        ird_d  = i_pop  ? bump(ird_q) : ird_q;
        dcnt_d = dcnt_q + cnt_t'(d_push) - cnt_t'(d_pop);
        icnt_d = icnt_q + cnt_t'(i_push) - cnt_t'(i_pop);

        vld_d  = vld_q;
        addr_d = addr_q;
        data_d = data_q;
        if (issue) begin
            vld_d  = 1'b1;
            addr_d = idest[ird_q];
            data_d = dmem[drd_q];
        end else if (dtn_ready) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            dwr_q  <= '0;
            drd_q  <= '0;
            iwr_q  <= '0;
            ird_q  <= '0;
            dcnt_q <= '0;
            icnt_q <= '0;
            vld_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            dwr_q  <= dwr_d;
            drd_q  <= drd_d;
            iwr_q  <= iwr_d;
            ird_q  <= ird_d;
            dcnt_q <= dcnt_d;
            icnt_q <= icnt_d;
            vld_q  <= vld_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    always_ff @(posedge clock) begin
        if (d_push) dmem[dwr_q] <= pu_data;
        if (i_push) begin
            idest[iwr_q] <= cu_dest;
            ilast[iwr_q] <= cu_last;
        end
    end

    assign dtn_valid = vld_q;
    assign dtn_addr  = addr_q;
    assign dtn_data  = data_q;
    assign dtn_from  = ADDR_WIDTH'(FROM_ADDR);
    assign idle      = (dcnt_q == '0) & (icnt_q == '0) & ~vld_q;

endmodule

// File: tb/tb_buffer_output_multicast.sv
// Directed bench for buffer_output_multicast: move, multicast,
// backpressure, pointer wrap and mid-transfer reset.
module tb_buffer_output_multicast;

    localparam int AW = 4;
    localparam int DW = 64;
    localparam int FROM = 6;

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic          pu_valid = 1'b0;
    logic          pu_ready;
    logic [DW-1:0] pu_data = '0;
    logic          cu_valid = 1'b0;
    logic          cu_ready;
    logic [AW-1:0] cu_dest = '0;
    logic          cu_last = 1'b0;
    logic          dtn_valid;
    logic          dtn_ready = 1'b0;
    logic [AW-1:0] dtn_addr;
    logic [AW-1:0] dtn_from;
    logic [DW-1:0] dtn_data;
    logic          idle;

    int errors = 0;
    int checks = 0;

    buffer_output_multicast #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH(5),
        .FROM_ADDR(FROM)
    ) dut (
        .clock(clock),
        .rst_n(rst_n),
        .pu_valid(pu_valid),
        .pu_ready(pu_ready),
        .pu_data(pu_data),
        .cu_valid(cu_valid),
        .cu_ready(cu_ready),
        .cu_dest(cu_dest),
        .cu_last(cu_last),
        .dtn_valid(dtn_valid),
        .dtn_ready(dtn_ready),
        .dtn_addr(dtn_addr),
        .dtn_from(dtn_from),
        .dtn_data(dtn_data),
        .idle(idle)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk_msg(input string tag, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        check({tag, ".v"}, 64'(dtn_valid), 64'd1);
        check({tag, ".a"}, 64'(dtn_addr), 64'(a));
        check({tag, ".d"}, dtn_data, d);
    endtask

    logic [AW-1:0] hold_a;
    logic [DW-1:0] hold_d;
    int sent_d, sent_i, rcv, ncyc;

    initial begin
        // Reset state
        #2;
        check("rst.valid", 64'(dtn_valid), 64'd0);
        check("rst.pu_rdy", 64'(pu_ready), 64'd0);
        check("rst.cu_rdy", 64'(cu_ready), 64'd0);
        check("rst.idle", 64'(idle), 64'd1);
        check("rst.addr", 64'(dtn_addr), 64'd0);
        check("rst.data", dtn_data, 64'd0);
        check("rst.from", 64'(dtn_from), 64'(FROM));
        @(negedge clock);
        rst_n = 1'b1;
        #1;
        check("rel.pu_rdy", 64'(pu_ready), 64'd1);
        check("rel.cu_rdy", 64'(cu_ready), 64'd1);

        // Basic move
        @(negedge clock);
        pu_valid = 1; pu_data = 64'hAA;
        cu_valid = 1; cu_dest = 4'd3; cu_last = 1;
        cyc();
        pu_valid = 0; cu_valid = 0;
        check("mv.v0", 64'(dtn_valid), 64'd0);
        check("mv.busy", 64'(idle), 64'd0);
        dtn_ready = 1;
        cyc();
        chk_msg("mv", 4'd3, 64'hAA);
        check("mv.from", 64'(dtn_from), 64'(FROM));
        cyc();
        check("mv.v1", 64'(dtn_valid), 64'd0);
        check("mv.idle", 64'(idle), 64'd1);

        // Multicast one word to 2, 5, 7
        pu_valid = 1; pu_data = 64'h55;
        cu_valid = 1; cu_dest = 4'd2; cu_last = 0;
        cyc();
        pu_valid = 0;
        cu_dest = 4'd5; cu_last = 0;
        cyc();
        chk_msg("mc0", 4'd2, 64'h55);
        cu_dest = 4'd7; cu_last = 1;
        cyc();
        chk_msg("mc1", 4'd5, 64'h55);
        cu_valid = 0;
        cyc();
        chk_msg("mc2", 4'd7, 64'h55);
        cyc();
        check("mc.v", 64'(dtn_valid), 64'd0);
        check("mc.idle", 64'(idle), 64'd1);

        // Backpressure: one message held plus both FIFOs full
        dtn_ready = 0;
        for (int i = 0; i < 6; i++) begin
            pu_valid = 1; pu_data = 64'h100 + 64'(i);
            cu_valid = 1; cu_dest = AW'(i + 1); cu_last = 1;
            cyc();
        end
        pu_valid = 0; cu_valid = 0;
        check("bp.pu_rdy", 64'(pu_ready), 64'd0);
        check("bp.cu_rdy", 64'(cu_ready), 64'd0);
        chk_msg("bp.head", 4'd1, 64'h100);
        hold_a = dtn_addr;
        hold_d = dtn_data;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("bp.hold.v", 64'(dtn_valid), 64'd1);
            check("bp.hold.a", 64'(dtn_addr), 64'(hold_a));
            check("bp.hold.d", dtn_data, hold_d);
        end
        check("bp.full", 64'(pu_ready), 64'd0);
        dtn_ready = 1;
        for (int i = 1; i < 6; i++) begin
            cyc();
            chk_msg("bp.drain", AW'(i + 1), 64'h100 + 64'(i));
        end
        cyc();
        check("bp.end.v", 64'(dtn_valid), 64'd0);
        check("bp.end.idle", 64'(idle), 64'd1);

        // Wrap-around with random valids and ready
        sent_d = 0; sent_i = 0; rcv = 0; ncyc = 0;
        while (rcv < 40 && ncyc < 3000) begin
            pu_valid = (sent_d < 40) && ($urandom_range(3) != 0);
            pu_data  = 64'hD000 + 64'(sent_d);
            cu_valid = (sent_i < 40) && ($urandom_range(3) != 0);
            cu_dest  = AW'(sent_i);
            cu_last  = 1;
            dtn_ready = ($urandom_range(2) != 0);
            #1;
            if (dtn_valid && dtn_ready) begin
                chk_msg("wrap", AW'(rcv), 64'hD000 + 64'(rcv));
                rcv++;
            end
            if (pu_valid && pu_ready) sent_d++;
            if (cu_valid && cu_ready) sent_i++;
            cyc();
            ncyc++;
        end
        check("wrap.count", 64'(rcv), 64'd40);
        pu_valid = 0; cu_valid = 0; dtn_ready = 1;
        cyc();
        check("wrap.idle", 64'(idle), 64'd1);

        // Reset while a message is pending and 3 entries queued
        dtn_ready = 0;
        for (int i = 0; i < 4; i++) begin
            pu_valid = 1; pu_data = 64'hE0 + 64'(i);
            cu_valid = 1; cu_dest = AW'(8 + i); cu_last = 1;
            cyc();
        end
        pu_valid = 0; cu_valid = 0;
        chk_msg("mr.pre", 4'd8, 64'hE0);
        #2 rst_n = 0;
        #1;
        check("mr.v", 64'(dtn_valid), 64'd0);
        check("mr.idle", 64'(idle), 64'd1);
        check("mr.pu_rdy", 64'(pu_ready), 64'd0);
        check("mr.addr", 64'(dtn_addr), 64'd0);
        @(negedge clock);
        rst_n = 1;
        dtn_ready = 1;
        #1;
        check("mr.rel.pu", 64'(pu_ready), 64'd1);
        check("mr.rel.cu", 64'(cu_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("mr.stale", 64'(dtn_valid), 64'd0);
        end
        pu_valid = 1; pu_data = 64'h77;
        cu_valid = 1; cu_dest = 4'd4; cu_last = 1;
        cyc();
        pu_valid = 0; cu_valid = 0;
        check("mr.lat", 64'(dtn_valid), 64'd0);
        cyc();
        chk_msg("mr.new", 4'd4, 64'h77);
        cyc();
        check("mr.idle2", 64'(idle), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
